reg_wb_port: RTL

Write-back port for the 16-entry register file. It is the writer-side counterpart of the register read ports. It accepts ALU/MDU results through a valid/ready handshake and stages them in a one-entry WB register. It drives the register file write strobe and sequences double-width results as two writes: the low half to the destination register, then the high half to R0. It also generates the reg_forward select codes (00 file, 01 WB, 10 R0), the wrd value and the r0d value consumed by the read ports.

---
 rtl/reg_pkg.sv | 20 ++
 rtl/reg_fwd_sel.sv | 24 ++
 rtl/reg_wb_port.sv | 133 +++++++++++++
 3 files changed

// File: rtl/reg_pkg.sv
// Shared definitions for the register file write-back port: forward-select codes,
// write-back FSM state encoding and default widths.
package reg_pkg;

    localparam int REG_DATA_WIDTH_DEF    = 16;
    localparam int REG_NUM_WIDTH_DEF     = 4;
    localparam int REG_FORWARD_WIDTH_DEF = 2;
    localparam int NUM_REGISTERS_DEF     = 16;

    localparam logic [1:0] REG_FORWARD_REG_FILE = 2'b00;
    localparam logic [1:0] REG_FORWARD_WB       = 2'b01;
    localparam logic [1:0] REG_FORWARD_R0       = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WB   = 2'b01,
        S_R0   = 2'b10
    } wb_state_t;

endpackage

// File: rtl/reg_fwd_sel.sv
// Forward-select compare for one read port: picks file, WB register or pending R0 half.
// Purely combinational, zero latency; no backpressure.
module reg_fwd_sel
    import reg_pkg::*;
#(
    parameter int REG_NUM_WIDTH     = REG_NUM_WIDTH_DEF,
    parameter int REG_FORWARD_WIDTH = REG_FORWARD_WIDTH_DEF
) (
    input  logic [1:0]                   state,
    input  logic [REG_NUM_WIDTH-1:0]     rn,
    input  logic [REG_NUM_WIDTH-1:0]     wb_rn,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward
);

    always_comb begin
        reg_forward = REG_FORWARD_WIDTH'(REG_FORWARD_REG_FILE);
        if (state == S_R0 && rn == '0) begin
            reg_forward = REG_FORWARD_WIDTH'(REG_FORWARD_R0);
        end else if (state == S_WB && rn == wb_rn) begin
            reg_forward = REG_FORWARD_WIDTH'(REG_FORWARD_WB);
        end
    end

endmodule

// File: rtl/reg_wb_port.sv
// Register file write-back port: stages results, splits doubles into rd then R0 writes.
// Latency: write strobe one cycle after accept; in_ready drops for one cycle per double.
// Optional REG_WB_PERF_EN adds a saturating write counter output wb_count.
module reg_wb_port
    import reg_pkg::*;
#(
    parameter int REG_DATA_WIDTH    = REG_DATA_WIDTH_DEF,
    parameter int REG_NUM_WIDTH     = REG_NUM_WIDTH_DEF,
    parameter int REG_FORWARD_WIDTH = REG_FORWARD_WIDTH_DEF,
    parameter int NUM_REGISTERS     = NUM_REGISTERS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [REG_NUM_WIDTH-1:0]     in_rn,
    input  logic [REG_DATA_WIDTH-1:0]    in_data,
    input  logic [REG_DATA_WIDTH-1:0]    in_data_hi,
    input  logic                         in_dbl,
    output logic                         wr_en,
    output logic [REG_NUM_WIDTH-1:0]     wr_rn,
    output logic [REG_DATA_WIDTH-1:0]    wr_data,
    input  logic [REG_NUM_WIDTH-1:0]     rn_a,
    input  logic [REG_NUM_WIDTH-1:0]     rn_b,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_a,
    output logic [REG_FORWARD_WIDTH-1:0] reg_forward_b,
    output logic [REG_DATA_WIDTH-1:0]    wrd,
    output logic [REG_DATA_WIDTH-1:0]    r0d,
    output logic                         exception
`ifdef REG_WB_PERF_EN
    ,
    output logic [15:0]                  wb_count
`endif
);

    wb_state_t                  state_q, state_d;
    logic [REG_NUM_WIDTH-1:0]   wb_rn;
    logic [REG_DATA_WIDTH-1:0]  wb_hi;
    logic                       wb_dbl;
    logic                       accept;
    logic                       legal;

    // The R0 half of a double must follow its low half, so no accept in between.
    assign in_ready = rst && !(state_q == S_WB && wb_dbl);
    assign accept   = in_valid && in_ready;
    assign legal    = (32'(in_rn) < NUM_REGISTERS);
    assign wrd      = wr_data;

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_WB: begin
                if (wb_dbl) begin
                    state_d = S_R0;
                end else if (accept && legal) begin
                    state_d = S_WB;
                end
            end
            default: begin
                if (accept && legal) begin
                    state_d = S_WB;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wb_rn     <= '0;
            wb_hi     <= '0;
            wb_dbl    <= 1'b0;
            wr_en     <= 1'b0;
            wr_rn     <= '0;
            wr_data   <= '0;
            r0d       <= '0;
            exception <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en     <= (state_d != S_IDLE);
            exception <= accept && !legal;
            case (state_d)
                S_WB: begin
                    wb_rn   <= in_rn;
                    wb_hi   <= in_data_hi;
                    wb_dbl  <= in_dbl;
                    wr_rn   <= in_rn;
                    wr_data <= in_data;
                end
                S_R0: begin
                    wb_dbl  <= 1'b0;
                    wr_rn   <= '0;
                    wr_data <= wb_hi;
                    r0d     <= wb_hi;
                end
                default: begin
                    wb_dbl  <= 1'b0;
                end
            endcase
        end
    end

    reg_fwd_sel #(
        .REG_NUM_WIDTH    (REG_NUM_WIDTH),
        .REG_FORWARD_WIDTH(REG_FORWARD_WIDTH)
    ) u_fwd_a (
        .state      (state_q),
        .rn         (rn_a),
        .wb_rn      (wb_rn),
        .reg_forward(reg_forward_a)
    );

    reg_fwd_sel #(
        .REG_NUM_WIDTH    (REG_NUM_WIDTH),
        .REG_FORWARD_WIDTH(REG_FORWARD_WIDTH)
    ) u_fwd_b (
        .state      (state_q),
        .rn         (rn_b),
        .wb_rn      (wb_rn),
        .reg_forward(reg_forward_b)
    );

`ifdef REG_WB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count <= '0;
        end else if (wr_en && wb_count != 16'hFFFF) begin
            wb_count <= wb_count + 16'd1;
        end
    end
`endif

endmodule
